pe_fp16_ws_v2: RTL and testbench
================================

Name: pe_fp16_ws_v2

Overview:
- Next-generation weight-stationary FP16 processing element for the systolic array.
- Adds a ping-pong weight bank of NUM_W entries, so new weights load while the array computes.
- Adds per-sample weight select, valid tracking through the MAC pipeline, and per-sample modes (MAC / MUL / BYPASS).
- Adds a saturating op counter. Instantiates the existing 9-cycle pipelined MAC_FP_16 and forwards ifmap to the right-hand neighbour with 1-cycle delay.

Parameters:
- MAC_LAT, 9, latency of MAC_FP_16 in cycles. Must equal the real MAC latency; the bypass/valid delay lines use it.
- NUM_W, 4, weight entries per bank (≥1). WSEL_W = max(1, clog2(NUM_W)).
- CNT_W, 32, width of the valid-op counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- load_en  in  1  write weight_in into shadow bank at load_addr
- load_addr  in  WSEL_W  shadow bank write index
- weight_in  in  16  FP16 weight
- bank_swap  in  1  one-cycle pulse: shadow and active banks exchange roles
- in_valid  in  1  ifmap/psum sample valid
- ifmap_in  in  16  FP16 activation
- w_sel  in  WSEL_W  active-bank index used with this sample
- mode  in  2  00 MAC, 01 MUL (C=+0), 10 BYPASS, 11 treated as BYPASS
- psum_in  in  16  FP16 partial sum from the PE above
- ifmap_out  out  16  registered ifmap_in
- ifmap_valid_out  out  1  registered in_valid
- w_sel_out  out  WSEL_W  registered w_sel
- mode_out  out  2  registered mode
- psum_out  out  16  result; forced to 16'h0000 when out_valid=0
- out_valid  out  1  psum_out valid
- active_bank  out  1  index of the current active bank
- op_count  out  CNT_W  saturating count of in_valid cycles with mode MAC or MUL
- cnt_clr  in  1  synchronous clear of op_count

Behaviour:
- One clock domain. Reset is synchronous and active-high on clk/rst.
- rst is also driven into MAC_FP_16.
- Reset values:
  - All weights in both banks = 16'h0000.
  - active_bank = 0.
  - ifmap_out, w_sel_out, mode_out = 0; ifmap_valid_out = 0.
  - All delay-line valids = 0, so out_valid = 0 and psum_out = 0 from the cycle after rst is sampled.
  - op_count = 0.
- Reset mid-operation: every in-flight sample is discarded. No out_valid may assert for a sample accepted before or during rst.
- Weight banks:
  - Two banks of NUM_W × 16 registers. Shadow bank = ~active_bank.
  - load_en writes weight_in into shadow[load_addr] at the clock edge.
  - If load_addr ≥ NUM_W (non-power-of-2 NUM_W), the write is ignored.
- bank_swap:
  - Toggles active_bank at the edge.
  - Reads in the same cycle use the pre-swap active bank.
  - A load_en in the same cycle writes the pre-swap shadow bank, which is active from the next cycle.
  - Swap while samples are in flight is legal: in-flight samples keep the weight they launched with.
- Launch cycle N (in_valid=1):
  - MAC A = ifmap_in.
  - MAC B = active[w_sel]; w_sel ≥ NUM_W reads 16'h0000.
  - MAC C = psum_in (MAC) or 16'h0000 (MUL).
  - When in_valid=0 or mode is BYPASS, A is driven to 16'h0000 (power gating); the result is unused.
- Alignment pipeline:
  - in_valid, mode-is-bypass flag and psum_in enter MAC_LAT-deep delay lines in parallel with the MAC.
  - At cycle N+MAC_LAT, out_valid = 1.
  - psum_out = delayed psum_in if bypass, else Acc_Out.
  - This gives a fixed latency of MAC_LAT for every mode, so column timing never depends on mode.
  - Throughput: 1 sample per cycle, no backpressure.
- Forwarding: ifmap_out, ifmap_valid_out, w_sel_out and mode_out are 1-cycle registers, updated every cycle whether or not in_valid is set.
- op_count:
  - Increments on in_valid & mode∈{MAC,MUL} and saturates at all-ones.
  - cnt_clr has priority over increment in the same cycle; the result is 0.

Decomposition:
- Package pe_pkg holds:
  - mode encodings MODE_MAC=2'b00, MODE_MUL=2'b01, MODE_BYP=2'b10;
  - FP16_ZERO=16'h0000;
  - FP16_W=16;
  - MAC_FP16_LAT=9 (the default for MAC_LAT).
- One sub-module, pe_delay_line (parameters WIDTH, DEPTH; sync active-high reset clears all stages). It is instantiated for the valid, bypass-flag and bypass-psum lines.
- MAC_FP_16 is reused unchanged.

Test Plan:
- Load weight_in=16'h4000 (2.0) at addr 0, pulse bank_swap, then in_valid with ifmap_in=16'h4200 (3.0), psum_in=16'h3C00 (1.0), mode=MAC, w_sel=0 → out_valid after exactly 9 cycles, psum_out=16'h4700 (7.0); ifmap_out=16'h4200 after 1 cycle.
- Same weights, mode=MUL, psum_in=16'h3C00 → psum_out=16'h4600 (6.0). Then mode=BYPASS, psum_in=16'h1234 → psum_out=16'h1234 at +9; op_count=2.
- Back-to-back streaming:
  - Stimulus: 9 consecutive samples, w_sel cycling 0..3, bank holding 1.0/2.0/0.5/-1.0 (3C00/4000/3800/BC00), ifmap=16'h4000, psum=0.
  - Required: 9 consecutive out_valid with psum_out = 4000, 4400, 3C00, C000, 4000, 4400, 3C00, C000, 4000.
- Same-cycle bank_swap + load_en to addr 0 with 16'h3800, while a sample is in flight using the old bank (weight 2.0):
  - The in-flight result uses 2.0.
  - The next sample uses 0.5.
  - active_bank toggles exactly once.
- Assert rst for 1 cycle at cycle 4 of a 9-deep burst → out_valid stays 0 for the whole burst; psum_out=0; op_count=0; weights=0.
- CNT_W=4: 20 MAC samples → op_count=15. Then cnt_clr together with in_valid → 0.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared encodings and constants for the FP16 weight-stationary processing element.
package pe_pkg;

   localparam int FP16_W       = 16;
   localparam int MAC_FP16_LAT = 9;

   localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;

   // Per-sample operating mode; 2'b11 behaves exactly like BYPASS.
   typedef enum logic [1:0] {
      MODE_MAC     = 2'b00,
      MODE_MUL     = 2'b01,
      MODE_BYP     = 2'b10,
      MODE_BYP_ALT = 2'b11
   } pe_mode_e;

   // Both upper encodings route psum_in straight through.
   function automatic logic mode_is_bypass(input logic [1:0] m);
      return m[1];
   endfunction

   // Only arithmetic modes count as operations.
   function automatic logic mode_is_arith(input logic [1:0] m);
      return ~m[1];
   endfunction

endpackage

// File: rtl/MAC_FP_16.sv
// FP16 fused multiply-add Acc_Out = A*B + C, 9-cycle latency, round to
// nearest even. The sum is formed exactly in a wide fixed-point word (LSB
// weight 2^-48) and rounded once. Any Inf/NaN operand yields a quiet NaN.
module MAC_FP_16 (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] A,
   input  logic [15:0] B,
   input  logic [15:0] C,
   output logic [15:0] Acc_Out
);

   localparam int STAGES = 9;
   localparam int SUM_W  = 82;

   logic [15:0]      stage_d [STAGES];
   logic [15:0]      stage_q [STAGES];

   logic [4:0]       ea, eb, ec;
   logic [10:0]      ma, mb, mc;
   logic [21:0]      prod;
   logic [SUM_W-1:0] pv, cv, mag;
   logic             ps, rs, rnd, stk;
   logic [6:0]       lead, lsb, ebase;
   logic [11:0]      mant;
   logic [16:0]      res;
   logic [15:0]      result;

   // Position of the most significant set bit (0 for an all-zero word).
   function automatic logic [6:0] lead_one(input logic [SUM_W-1:0] v);
      logic [6:0] pos;
      pos = 7'd0;
      for (int i = 0; i < SUM_W; i++) begin
         if (v[i]) begin
            pos = 7'(i);
         end else begin
            pos = pos;
         end
      end
      return pos;
   endfunction

   // Exact product-plus-addend, then a single normalise and round step.
   always_comb begin
      ma = {(A[14:10] != 5'd0), A[9:0]};
      mb = {(B[14:10] != 5'd0), B[9:0]};
      mc = {(C[14:10] != 5'd0), C[9:0]};
      ea = (A[14:10] == 5'd0) ? 5'd1 : A[14:10];
      eb = (B[14:10] == 5'd0) ? 5'd1 : B[14:10];
      ec = (C[14:10] == 5'd0) ? 5'd1 : C[14:10];
      prod = {11'd0, ma} * {11'd0, mb};
      pv = {60'd0, prod} << ({2'd0, ea} + {2'd0, eb} - 7'd2);
      cv = {71'd0, mc} << ({2'd0, ec} + 7'd23);
      ps = A[15] ^ B[15];
      if (ps == C[15]) begin
         mag = pv + cv;
         rs  = ps;
      end else if (pv >= cv) begin
         mag = pv - cv;
         rs  = ps;
      end else begin
         mag = cv - pv;
         rs  = C[15];
      end
      lead = lead_one(mag);
      // Normal results keep 11 bits below the leading one; smaller ones
      // are pinned to the subnormal grid (LSB weight 2^-24).
      if (lead >= 7'd34) begin
         ebase = lead - 7'd33;
         lsb   = lead - 7'd10;
      end else begin
         ebase = 7'd1;
         lsb   = 7'd24;
      end
      mant = 12'(mag >> lsb);
      rnd  = mag[lsb - 7'd1];
      stk  = |(mag & ((82'd1 << (lsb - 7'd1)) - 82'd1));
      if (rnd && (stk || mant[0])) begin
         mant = mant + 12'd1;
      end else begin
         mant = mant;
      end
      // Adding the hidden bit onto (exp-1) lets a rounding carry bump the exponent.
      res = {ebase - 7'd1, 10'd0} + {5'd0, mant};
      if ((A[14:10] == 5'h1F) || (B[14:10] == 5'h1F) || (C[14:10] == 5'h1F)) begin
         result = 16'h7E00;
      end else if (mag == {SUM_W{1'b0}}) begin
         result = 16'h0000;
      end else if (res >= 17'h07C00) begin
         result = {rs, 15'h7C00};
      end else begin
         result = {rs, res[14:0]};
      end
   end

   // Pipeline next state: result enters stage 0 and shifts down.
   always_comb begin
      stage_d[0] = result;
      for (int i = 1; i < STAGES; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   // Pipeline registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) begin
            stage_q[i] <= 16'h0000;
         end
      end else begin
         stage_q <= stage_d;
      end
   end

   assign Acc_Out = stage_q[STAGES-1];

endmodule

// File: rtl/pe_delay_line.sv
// Fixed-depth shift register; synchronous reset clears every stage.
module pe_delay_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage_d [DEPTH];
   logic [WIDTH-1:0] stage_q [DEPTH];

   // Next state: each stage takes the value of the one before it.
   always_comb begin
      stage_d[0] = d;
      for (int i = 1; i < DEPTH; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   // Stage registers, cleared on reset so nothing stale escapes.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= {WIDTH{1'b0}};
         end
      end else begin
         stage_q <= stage_d;
      end
   end

   assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/pe_fp16_ws_v2.sv
// Weight-stationary FP16 PE with ping-pong weight banks, per-sample weight
// select and mode, fixed MAC_LAT result latency and a saturating op counter.
module pe_fp16_ws_v2
   import pe_pkg::*;
#(
   parameter int MAC_LAT = MAC_FP16_LAT,
   parameter int NUM_W   = 4,
   parameter int WSEL_W  = (NUM_W > 1) ? $clog2(NUM_W) : 1,
   parameter int CNT_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_en,
   input  logic [WSEL_W-1:0] load_addr,
   input  logic [15:0]       weight_in,
   input  logic              bank_swap,
   input  logic              in_valid,
   input  logic [15:0]       ifmap_in,
   input  logic [WSEL_W-1:0] w_sel,
   input  logic [1:0]        mode,
   input  logic [15:0]       psum_in,
   output logic [15:0]       ifmap_out,
   output logic              ifmap_valid_out,
   output logic [WSEL_W-1:0] w_sel_out,
   output logic [1:0]        mode_out,
   output logic [15:0]       psum_out,
   output logic              out_valid,
   output logic              active_bank,
   output logic [CNT_W-1:0]  op_count,
   input  logic              cnt_clr
);

   localparam logic [WSEL_W:0] NUM_W_L = (WSEL_W+1)'(NUM_W);

   logic [FP16_W-1:0] bank_d [2][NUM_W];
   logic [FP16_W-1:0] bank_q [2][NUM_W];
   logic              active_d, active_q;
   logic [15:0]       ifmap_d, ifmap_q;
   logic              ifv_d, ifv_q;
   logic [WSEL_W-1:0] wsel_d, wsel_q;
   logic [1:0]        mode_d, mode_q;
   logic [CNT_W-1:0]  cnt_d, cnt_q;

   logic              byp;
   logic [15:0]       weight_rd;
   logic [15:0]       mac_a, mac_c;
   logic [15:0]       acc_out;
   logic              vld_dly, byp_dly;
   logic [15:0]       psum_dly;
   logic [15:0]       psum_mux;

   // Shadow-bank write and bank swap; same-cycle load targets the pre-swap shadow.
   always_comb begin
      bank_d = bank_q;
      if (load_en && ({1'b0, load_addr} < NUM_W_L)) begin
         bank_d[~active_q][load_addr] = weight_in;
      end else begin
         bank_d = bank_q;
      end
      if (bank_swap) begin
         active_d = ~active_q;
      end else begin
         active_d = active_q;
      end
   end

   // Operand selection: weight from the pre-swap active bank, A gated when unused.
   always_comb begin
      byp = mode_is_bypass(mode);
      if ({1'b0, w_sel} < NUM_W_L) begin
         weight_rd = bank_q[active_q][w_sel];
      end else begin
         weight_rd = FP16_ZERO;
      end
      if (in_valid && !byp) begin
         mac_a = ifmap_in;
      end else begin
         mac_a = FP16_ZERO;
      end
      if (mode == MODE_MUL) begin
         mac_c = FP16_ZERO;
      end else begin
         mac_c = psum_in;
      end
   end

   // Forwarding and op-counter next state; clear beats increment, count saturates.
   always_comb begin
      ifmap_d = ifmap_in;
      ifv_d   = in_valid;
      wsel_d  = w_sel;
      mode_d  = mode;
      if (cnt_clr) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (in_valid && mode_is_arith(mode) && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Weight bank storage and active-bank pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < NUM_W; i++) begin
               bank_q[b][i] <= FP16_ZERO;
            end
         end
         active_q <= 1'b0;
      end else begin
         bank_q   <= bank_d;
         active_q <= active_d;
      end
   end

   // One-cycle forwarding registers to the right-hand neighbour and op counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         ifmap_q <= 16'h0000;
         ifv_q   <= 1'b0;
         wsel_q  <= {WSEL_W{1'b0}};
         mode_q  <= 2'b00;
         cnt_q   <= {CNT_W{1'b0}};
      end else begin
         ifmap_q <= ifmap_d;
         ifv_q   <= ifv_d;
         wsel_q  <= wsel_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
      end
   end

   MAC_FP_16 u_mac (
      .clk     (clk),
      .rst     (rst),
      .A       (mac_a),
      .B       (weight_rd),
      .C       (mac_c),
      .Acc_Out (acc_out)
   );

   pe_delay_line #(.WIDTH(1), .DEPTH(MAC_LAT)) u_vld_dly (
      .clk (clk),
      .rst (rst),
      .d   (in_valid),
      .q   (vld_dly)
   );

   pe_delay_line #(.WIDTH(1), .DEPTH(MAC_LAT)) u_byp_dly (
      .clk (clk),
      .rst (rst),
      .d   (byp),
      .q   (byp_dly)
   );

   pe_delay_line #(.WIDTH(16), .DEPTH(MAC_LAT)) u_psum_dly (
      .clk (clk),
      .rst (rst),
      .d   (psum_in),
      .q   (psum_dly)
   );

   // Result select aligned with the MAC output; zero whenever nothing is valid.
   always_comb begin
      if (!vld_dly) begin
         psum_mux = FP16_ZERO;
      end else if (byp_dly) begin
         psum_mux = psum_dly;
      end else begin
         psum_mux = acc_out;
      end
   end

   assign psum_out        = psum_mux;
   assign out_valid       = vld_dly;
   assign ifmap_out       = ifmap_q;
   assign ifmap_valid_out = ifv_q;
   assign w_sel_out       = wsel_q;
   assign mode_out        = mode_q;
   assign active_bank     = active_q;
   assign op_count        = cnt_q;

endmodule

// File: tb/tb_pe_fp16_ws_v2.sv
// Directed self-checking bench for pe_fp16_ws_v2 (default build plus a CNT_W=4 build).
module tb_pe_fp16_ws_v2;

   logic        clk;
   logic        rst;
   logic        load_en;
   logic [1:0]  load_addr;
   logic [15:0] weight_in;
   logic        bank_swap;
   logic        in_valid;
   logic [15:0] ifmap_in;
   logic [1:0]  w_sel;
   logic [1:0]  mode;
   logic [15:0] psum_in;
   logic        cnt_clr;

   logic [15:0] ifmap_out;
   logic        ifmap_valid_out;
   logic [1:0]  w_sel_out;
   logic [1:0]  mode_out;
   logic [15:0] psum_out;
   logic        out_valid;
   logic        active_bank;
   logic [31:0] op_count;

   logic [15:0] d4_ifmap_out;
   logic        d4_ifmap_valid_out;
   logic [1:0]  d4_w_sel_out;
   logic [1:0]  d4_mode_out;
   logic [15:0] d4_psum_out;
   logic        d4_out_valid;
   logic        d4_active_bank;
   logic [3:0]  d4_op_count;

   int n_checks = 0;
   int n_fail   = 0;

   pe_fp16_ws_v2 dut (
      .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
      .weight_in(weight_in), .bank_swap(bank_swap), .in_valid(in_valid),
      .ifmap_in(ifmap_in), .w_sel(w_sel), .mode(mode), .psum_in(psum_in),
      .ifmap_out(ifmap_out), .ifmap_valid_out(ifmap_valid_out),
      .w_sel_out(w_sel_out), .mode_out(mode_out), .psum_out(psum_out),
      .out_valid(out_valid), .active_bank(active_bank), .op_count(op_count),
      .cnt_clr(cnt_clr)
   );

   pe_fp16_ws_v2 #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
      .weight_in(weight_in), .bank_swap(bank_swap), .in_valid(in_valid),
      .ifmap_in(ifmap_in), .w_sel(w_sel), .mode(mode), .psum_in(psum_in),
      .ifmap_out(d4_ifmap_out), .ifmap_valid_out(d4_ifmap_valid_out),
      .w_sel_out(d4_w_sel_out), .mode_out(d4_mode_out), .psum_out(d4_psum_out),
      .out_valid(d4_out_valid), .active_bank(d4_active_bank), .op_count(d4_op_count),
      .cnt_clr(cnt_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      load_en = 1'b0; load_addr = 2'd0; weight_in = 16'h0000; bank_swap = 1'b0;
      in_valid = 1'b0; ifmap_in = 16'h0000; w_sel = 2'd0; mode = 2'b00;
      psum_in = 16'h0000; cnt_clr = 1'b0;
   endtask

   task automatic drain();
      idle();
      repeat (12) tick();
   endtask

   task automatic load_w(input logic [1:0] a, input logic [15:0] w);
      load_en = 1'b1; load_addr = a; weight_in = w;
      tick();
      load_en = 1'b0;
   endtask

   task automatic swap();
      bank_swap = 1'b1;
      tick();
      bank_swap = 1'b0;
   endtask

   task automatic set_sample(input logic [15:0] ifm, input logic [1:0] ws,
                             input logic [1:0] md, input logic [15:0] ps);
      in_valid = 1'b1; ifmap_in = ifm; w_sel = ws; mode = md; psum_in = ps;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      tick();
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
      n_checks++; if (psum_out !== 16'h0000) begin n_fail++; $display("FAIL rst_psum_out: got %h expected 0000", psum_out); end
      n_checks++; if (active_bank !== 1'b0) begin n_fail++; $display("FAIL rst_active_bank: got %b expected 0", active_bank); end
      n_checks++; if (op_count !== 32'd0) begin n_fail++; $display("FAIL rst_op_count: got %0d expected 0", op_count); end
      n_checks++; if (ifmap_out !== 16'h0000) begin n_fail++; $display("FAIL rst_ifmap_out: got %h expected 0000", ifmap_out); end
      n_checks++; if (ifmap_valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_ifmap_valid_out: got %b expected 0", ifmap_valid_out); end
      n_checks++; if (w_sel_out !== 2'd0) begin n_fail++; $display("FAIL rst_w_sel_out: got %0d expected 0", w_sel_out); end
      n_checks++; if (mode_out !== 2'd0) begin n_fail++; $display("FAIL rst_mode_out: got %0d expected 0", mode_out); end
      rst = 1'b0;
      tick();
   endtask

   // 2.0 loaded into the shadow bank, swapped in; 3.0*2.0+1.0 = 7.0 at exactly +9.
   task automatic test_mac();
      load_w(2'd0, 16'h4000);
      swap();
      n_checks++; if (active_bank !== 1'b1) begin n_fail++; $display("FAIL mac_active_bank: got %b expected 1", active_bank); end
      for (int cyc = 0; cyc < 10; cyc++) begin
         if (cyc == 0) set_sample(16'h4200, 2'd0, 2'b00, 16'h3C00); else idle();
         tick();
         if (cyc == 0) begin
            n_checks++; if (ifmap_out !== 16'h4200) begin n_fail++; $display("FAIL mac_ifmap_out: got %h expected 4200", ifmap_out); end
            n_checks++; if (ifmap_valid_out !== 1'b1) begin n_fail++; $display("FAIL mac_ifmap_valid_out: got %b expected 1", ifmap_valid_out); end
         end
         if (cyc == 1) begin
            n_checks++; if (ifmap_valid_out !== 1'b0) begin n_fail++; $display("FAIL mac_ifmap_valid_idle: got %b expected 0", ifmap_valid_out); end
         end
         if (cyc == 8) begin
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mac_out_valid: got %b expected 1", out_valid); end
            n_checks++; if (psum_out !== 16'h4700) begin n_fail++; $display("FAIL mac_psum_out: got %h expected 4700", psum_out); end
         end else begin
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mac_latency[%0d]: got out_valid %b expected 0", cyc, out_valid); end
         end
      end
      n_checks++; if (psum_out !== 16'h0000) begin n_fail++; $display("FAIL mac_psum_idle: got %h expected 0000", psum_out); end
      drain();
   endtask

   // MUL ignores psum_in; BYPASS (10 and 11) passes psum_in through untouched.
   task automatic test_mul_bypass();
      logic [1:0]  md_tab  [3] = '{2'b01, 2'b10, 2'b11};
      logic [15:0] ps_tab  [3] = '{16'h3C00, 16'h1234, 16'h5678};
      logic [15:0] exp_tab [3] = '{16'h4600, 16'h1234, 16'h5678};
      for (int cyc = 0; cyc < 12; cyc++) begin
         int j;
         if (cyc < 3) set_sample(16'h4200, 2'd0, md_tab[cyc], ps_tab[cyc]); else idle();
         tick();
         if (cyc == 1) begin
            n_checks++; if (mode_out !== 2'b10) begin n_fail++; $display("FAIL mb_mode_out: got %b expected 10", mode_out); end
         end
         j = cyc - 8;
         if (j >= 0 && j < 3) begin
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mb_out_valid[%0d]: got %b expected 1", j, out_valid); end
            n_checks++; if (psum_out !== exp_tab[j]) begin n_fail++; $display("FAIL mb_psum_out[%0d]: got %h expected %h", j, psum_out, exp_tab[j]); end
         end else begin
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mb_idle_valid[%0d]: got %b expected 0", cyc, out_valid); end
         end
      end
      n_checks++; if (op_count !== 32'd2) begin n_fail++; $display("FAIL mb_op_count: got %0d expected 2", op_count); end
      drain();
   endtask

   // Nine samples in a row cycling through 1.0/2.0/0.5/-1.0 times 2.0.
   task automatic test_back_to_back();
      logic [15:0] w_tab   [4] = '{16'h3C00, 16'h4000, 16'h3800, 16'hBC00};
      logic [15:0] exp_tab [4] = '{16'h4000, 16'h4400, 16'h3C00, 16'hC000};
      for (int i = 0; i < 4; i++) load_w(2'(i), w_tab[i]);
      swap();
      n_checks++; if (active_bank !== 1'b0) begin n_fail++; $display("FAIL b2b_active_bank: got %b expected 0", active_bank); end
      for (int cyc = 0; cyc < 19; cyc++) begin
         int j;
         if (cyc < 9) set_sample(16'h4000, 2'(cyc % 4), 2'b00, 16'h0000); else idle();
         tick();
         j = cyc - 8;
         if (j >= 0 && j < 9) begin
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_out_valid[%0d]: got %b expected 1", j, out_valid); end
            n_checks++; if (psum_out !== exp_tab[j % 4]) begin n_fail++; $display("FAIL b2b_psum_out[%0d]: got %h expected %h", j, psum_out, exp_tab[j % 4]); end
         end else begin
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_valid[%0d]: got %b expected 0", cyc, out_valid); end
         end
      end
      n_checks++; if (op_count !== 32'd11) begin n_fail++; $display("FAIL b2b_op_count: got %0d expected 11", op_count); end
      drain();
   endtask

   // Swap plus load to addr 0 (0.5) in one cycle while older samples are in flight.
   task automatic test_swap_inflight();
      logic [1:0]  ws_tab  [3] = '{2'd1, 2'd0, 2'd0};
      logic [15:0] exp_tab [3] = '{16'h4600, 16'h4200, 16'h3E00};
      for (int cyc = 0; cyc < 14; cyc++) begin
         int j;
         if (cyc < 3) set_sample(16'h4200, ws_tab[cyc], 2'b00, 16'h0000); else idle();
         bank_swap = (cyc == 1);
         load_en   = (cyc == 1);
         load_addr = 2'd0;
         weight_in = 16'h3800;
         tick();
         if (cyc == 0) begin
            n_checks++; if (active_bank !== 1'b0) begin n_fail++; $display("FAIL swp_bank_before: got %b expected 0", active_bank); end
         end
         if (cyc == 1) begin
            n_checks++; if (active_bank !== 1'b1) begin n_fail++; $display("FAIL swp_bank_after: got %b expected 1", active_bank); end
         end
         j = cyc - 8;
         if (j >= 0 && j < 3) begin
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL swp_out_valid[%0d]: got %b expected 1", j, out_valid); end
            n_checks++; if (psum_out !== exp_tab[j]) begin n_fail++; $display("FAIL swp_psum_out[%0d]: got %h expected %h", j, psum_out, exp_tab[j]); end
         end else begin
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL swp_idle_valid[%0d]: got %b expected 0", cyc, out_valid); end
         end
      end
      n_checks++; if (active_bank !== 1'b1) begin n_fail++; $display("FAIL swp_bank_once: got %b expected 1", active_bank); end
      drain();
   endtask

   // One-cycle reset inside a burst discards all of it and clears weights and counter.
   task automatic test_reset_midburst();
      for (int cyc = 0; cyc < 5; cyc++) begin
         set_sample(16'h4000, 2'd0, 2'b00, 16'h3C00);
         rst = (cyc == 4);
         tick();
      end
      rst = 1'b0;
      idle();
      n_checks++; if (op_count !== 32'd0) begin n_fail++; $display("FAIL rmb_op_count: got %0d expected 0", op_count); end
      n_checks++; if (d4_op_count !== 4'd0) begin n_fail++; $display("FAIL rmb_op_count4: got %0d expected 0", d4_op_count); end
      n_checks++; if (active_bank !== 1'b0) begin n_fail++; $display("FAIL rmb_active_bank: got %b expected 0", active_bank); end
      n_checks++; if (ifmap_valid_out !== 1'b0) begin n_fail++; $display("FAIL rmb_ifmap_valid: got %b expected 0", ifmap_valid_out); end
      for (int cyc = 0; cyc < 12; cyc++) begin
         n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmb_out_valid[%0d]: got %b expected 0", cyc, out_valid); end
         n_checks++; if (psum_out !== 16'h0000) begin n_fail++; $display("FAIL rmb_psum_out[%0d]: got %h expected 0000", cyc, psum_out); end
         tick();
      end
      // Every weight in both banks must now read as zero: 2.0*0 = +0.
      for (int cyc = 0; cyc < 15; cyc++) begin
         int j;
         if (cyc < 5) set_sample(16'h4000, 2'(cyc % 4), 2'b01, 16'h3C00); else idle();
         bank_swap = (cyc == 3);
         tick();
         j = cyc - 8;
         if (j >= 0 && j < 5) begin
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rmb_w_valid[%0d]: got %b expected 1", j, out_valid); end
            n_checks++; if (psum_out !== 16'h0000) begin n_fail++; $display("FAIL rmb_weight_zero[%0d]: got %h expected 0000", j, psum_out); end
         end
      end
      drain();
   endtask

   // CNT_W=4 saturates at 15; clear wins over a same-cycle increment.
   task automatic test_counter();
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      n_checks++; if (op_count !== 32'd0) begin n_fail++; $display("FAIL cnt_clear: got %0d expected 0", op_count); end
      n_checks++; if (d4_op_count !== 4'd0) begin n_fail++; $display("FAIL cnt_clear4: got %0d expected 0", d4_op_count); end
      for (int i = 0; i < 20; i++) begin
         set_sample(16'h3C00, 2'd0, 2'b00, 16'h0000);
         tick();
         if (i == 14) begin
            n_checks++; if (d4_op_count !== 4'd15) begin n_fail++; $display("FAIL cnt_mid4: got %0d expected 15", d4_op_count); end
            n_checks++; if (op_count !== 32'd15) begin n_fail++; $display("FAIL cnt_mid: got %0d expected 15", op_count); end
         end
      end
      n_checks++; if (d4_op_count !== 4'd15) begin n_fail++; $display("FAIL cnt_saturate4: got %0d expected 15", d4_op_count); end
      n_checks++; if (op_count !== 32'd20) begin n_fail++; $display("FAIL cnt_twenty: got %0d expected 20", op_count); end
      set_sample(16'h3C00, 2'd0, 2'b00, 16'h0000);
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      n_checks++; if (op_count !== 32'd0) begin n_fail++; $display("FAIL cnt_clr_prio: got %0d expected 0", op_count); end
      n_checks++; if (d4_op_count !== 4'd0) begin n_fail++; $display("FAIL cnt_clr_prio4: got %0d expected 0", d4_op_count); end
      tick();
      n_checks++; if (d4_op_count !== 4'd1) begin n_fail++; $display("FAIL cnt_restart4: got %0d expected 1", d4_op_count); end
      drain();
   endtask

   initial begin
      rst = 1'b1;
      idle();
      test_reset();
      test_mac();
      test_mul_bypass();
      test_back_to_back();
      test_swap_inflight();
      test_reset_midburst();
      test_counter();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
